// File: rtl/freq_meas_pkg.sv
// Shared constants for the clock-frequency measurement blocks.
package freq_meas_pkg;

    // Measurement FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_TRACK  = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    // Default counter width and lock depth
    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned LOCK_CNT_DEF = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus rising-edge detect.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic async_in,
    output logic lvl,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_d;

    // Shift the async input through the synchronizer chain and keep one delayed copy
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
            lvl_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            lvl_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in sys_clk cycles.
module clk_period_meter
    import freq_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned   MATCH_W  = 4;
    localparam int unsigned   MATCH_W1 = MATCH_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic               lvl;
    logic               rise;
    logic [1:0]         state_q;
    logic [1:0]         state_nx;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   hi_cnt_q;
    logic [MATCH_W-1:0] match_q;
    logic [MATCH_W-1:0] match_nx;
    logic               active_c;
    logic               emit_c;
    logic               tmo_c;
    logic               same_c;
    logic               lock_hit_c;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .async_in  (clk_in),
        .lvl       (lvl),
        .rise      (rise)
    );

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state logic; a rise always wins over a simultaneous timeout
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_nx = ST_ARMED;
            end
            ST_ARMED: begin
                if (rise)       state_nx = ST_TRACK;
                else if (tmo_c) state_nx = ST_IDLE;
            end
            ST_TRACK: begin
                if (rise) begin
                    if (same_c && lock_hit_c) state_nx = ST_LOCKED;
                end else if (tmo_c) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (rise) begin
                    if (!same_c) state_nx = ST_TRACK;
                end else if (tmo_c) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Control decode: emit, timeout and match-counter update
    always_comb begin
        active_c   = (state_q != ST_IDLE);
        emit_c     = active_c & rise;
        tmo_c      = active_c & ~rise & (cnt_q == CNT_MAX);
        same_c     = (cnt_q == period);
        lock_hit_c = ((MATCH_W1'(match_q) + MATCH_W1'(1)) == MATCH_W1'(LOCK_CNT));
        match_nx   = match_q;
        if (tmo_c) begin
            match_nx = '0;
        end else if (emit_c) begin
            case (state_q)
                ST_TRACK:  match_nx = same_c ? (match_q + MATCH_W'(1)) : '0;
                ST_LOCKED: match_nx = same_c ? match_q : '0;
                default:   match_nx = '0;
            endcase
        end
    end

    // Period and high-time counters; reload on rise, saturate, hold in IDLE
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q    <= '0;
            hi_cnt_q <= '0;
            match_q  <= '0;
        end else begin
            match_q <= match_nx;
            if (rise) begin
                cnt_q    <= CNT_W'(1);
                hi_cnt_q <= CNT_W'(1);
            end else if (active_c) begin
                if (cnt_q != CNT_MAX)
                    cnt_q <= cnt_q + CNT_W'(1);
                if (lvl && (hi_cnt_q != CNT_MAX))
                    hi_cnt_q <= hi_cnt_q + CNT_W'(1);
            end
        end
    end

    // Registered measurement, lock and sticky timeout outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= emit_c;
            locked     <= (state_nx == ST_LOCKED);
            if (emit_c) begin
                period    <= cnt_q;
                high_time <= hi_cnt_q;
                timeout   <= 1'b0;
            end else if (tmo_c) begin
                timeout   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter (CNT_W = 8, LOCK_CNT = 2).
module tb_clk_period_meter;

    localparam int unsigned CNT_W = 8;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             clk_in    = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    int n_assert = 0;
    int n_fail   = 0;

    // Measurement log filled by the monitor
    int q_period[$];
    int q_high[$];
    int q_locked[$];
    int q_timeout[$];
    int q_cyc[$];
    int cyc          = 0;
    int tmo_cyc      = 0;
    logic timeout_prev = 1'b0;

    // Expected measurements built by the stimulus
    int e_period[$];
    int e_high[$];
    int e_locked[$];

    clk_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .LOCK_CNT    (2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .clk_in     (clk_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 sys_clk = ~sys_clk;

    // Record every meas_valid cycle and the cycle timeout first rises
    always @(negedge sys_clk) begin
        cyc          <= cyc + 1;
        timeout_prev <= timeout;
        if (timeout && !timeout_prev) tmo_cyc <= cyc;
        if (meas_valid) begin
            q_period.push_back(int'(period));
            q_high.push_back(int'(high_time));
            q_locked.push_back(int'(locked));
            q_timeout.push_back(int'(timeout));
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_periods(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            clk_in = 1'b1;
            repeat (hi) @(negedge sys_clk);
            clk_in = 1'b0;
            repeat (lo) @(negedge sys_clk);
        end
    endtask

    task automatic push_one(input int per, input int hi, input int lk);
        e_period.push_back(per);
        e_high.push_back(hi);
        e_locked.push_back(lk);
    endtask

    // A run of n equal measurements after a change: lock on the third one
    task automatic push_seg(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) push_one(per, hi, (i >= 2) ? 1 : 0);
    endtask

    task automatic check_log(input string tag, input int base);
        int got;
        int cmp;
        got = q_period.size() - base;
        check({tag, " count"}, 32'(got), 32'(e_period.size()));
        cmp = (got < e_period.size()) ? got : e_period.size();
        for (int i = 0; i < cmp; i++) begin
            check($sformatf("%s m%0d period", tag, i + 1), 32'(q_period[base+i]), 32'(e_period[i]));
            check($sformatf("%s m%0d high", tag, i + 1), 32'(q_high[base+i]), 32'(e_high[i]));
            check($sformatf("%s m%0d locked", tag, i + 1), 32'(q_locked[base+i]), 32'(e_locked[i]));
            check($sformatf("%s m%0d timeout", tag, i + 1), 32'(q_timeout[base+i]), 32'd0);
        end
        e_period.delete();
        e_high.delete();
        e_locked.delete();
    endtask

    initial begin
        int base;
        int last_cyc;

        // Reset values
        repeat (3) @(negedge sys_clk);
        check("rst period", 32'(period), 32'd0);
        check("rst high_time", 32'(high_time), 32'd0);
        check("rst meas_valid", 32'(meas_valid), 32'd0);
        check("rst locked", 32'(locked), 32'd0);
        check("rst timeout", 32'(timeout), 32'd0);
        sys_rst_n = 1'b1;

        // clk_in stuck low from reset: nothing happens, no timeout
        repeat (1000) @(negedge sys_clk);
        check("stuck count", 32'(q_period.size()), 32'd0);
        check("stuck timeout", 32'(timeout), 32'd0);
        check("stuck locked", 32'(locked), 32'd0);
        check("stuck period", 32'(period), 32'd0);

        // Div-8 (2/6), div-6, div-10, div-6, one trailing rise to flush
        base = q_period.size();
        drive_periods(2, 6, 5);
        drive_periods(3, 3, 6);
        drive_periods(5, 5, 6);
        drive_periods(3, 3, 5);
        clk_in = 1'b1;
        repeat (3) @(negedge sys_clk);
        clk_in = 1'b0;
        repeat (3) @(negedge sys_clk);
        push_seg(8, 2, 5);
        push_seg(6, 3, 6);
        push_seg(10, 5, 6);
        push_seg(6, 3, 5);
        check_log("track", base);
        check("pre-timeout timeout", 32'(timeout), 32'd0);
        check("pre-timeout locked", 32'(locked), 32'd1);

        // clk_in stopped low: timeout exactly 255 cycles after the last measurement
        last_cyc = q_cyc[q_cyc.size()-1];
        for (int k = 0; k < 600 && !timeout; k++) @(negedge sys_clk);
        @(negedge sys_clk);
        check("tmo timeout", 32'(timeout), 32'd1);
        check("tmo locked", 32'(locked), 32'd0);
        check("tmo period hold", 32'(period), 32'd6);
        check("tmo high hold", 32'(high_time), 32'd3);
        check("tmo latency", 32'(tmo_cyc - last_cyc), 32'd255);

        // Restart: first rise only arms, second rise measures and clears timeout
        base = q_period.size();
        drive_periods(3, 3, 1);
        check("restart arm count", 32'(q_period.size() - base), 32'd0);
        check("restart arm timeout", 32'(timeout), 32'd1);
        drive_periods(3, 3, 1);
        check("restart timeout", 32'(timeout), 32'd0);

        // Period of exactly 255: rise coinciding with cnt == max wins
        drive_periods(3, 252, 1);
        drive_periods(3, 3, 5);
        clk_in = 1'b1;
        repeat (4) @(negedge sys_clk);
        push_one(6, 3, 0);
        push_one(6, 3, 0);
        push_one(255, 3, 0);
        push_one(6, 3, 0);
        push_one(6, 3, 0);
        push_one(6, 3, 1);
        push_one(6, 3, 1);
        push_one(6, 3, 1);
        check_log("restart", base);
        check("max locked", 32'(locked), 32'd1);
        check("max timeout", 32'(timeout), 32'd0);

        // Asynchronous reset mid-period while locked
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("arst period", 32'(period), 32'd0);
        check("arst high_time", 32'(high_time), 32'd0);
        check("arst meas_valid", 32'(meas_valid), 32'd0);
        check("arst locked", 32'(locked), 32'd0);
        check("arst timeout", 32'(timeout), 32'd0);
        clk_in = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Measurement resumes normally after reset
        base = q_period.size();
        drive_periods(3, 3, 4);
        clk_in = 1'b1;
        repeat (4) @(negedge sys_clk);
        clk_in = 1'b0;
        push_seg(6, 3, 4);
        check_log("post-rst", base);
        check("post-rst locked", 32'(locked), 32'd1);

        repeat (5) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
